button_press_classifier: RTL and testbench

Consumes the debounced, clock-synchronous button level from the debounce stage and classifies each user gesture as a short press, long press, or double press. It emits a one-cycle pulse per classified gesture and keeps a wrapping event count. It sits directly downstream of the debouncer and upstream of the mode/LED control logic.

---
 rtl/button_pkg.sv | 18 +
 rtl/button_press_classifier.sv | 103 ++++++++++
 tb/tb_button_press_classifier.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types, defaults and tick conversion for the button front end
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HELD,
        WAIT2,
        PRESS2
    } state_t;

    localparam int DEFAULT_CLK_HZ = 12_000_000;

    function automatic int ms_to_ticks(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced presses as short, long or double
module button_press_classifier
    import button_pkg::*;
#(
    parameter int CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic [7:0] event_count
);

    localparam int LONG_TICKS   = ms_to_ticks(CLK_HZ, LONG_MS);
    localparam int DOUBLE_TICKS = ms_to_ticks(CLK_HZ, DOUBLE_MS);
    localparam int MAX_TICKS    = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
    localparam int TW           = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_TICKS - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          btn_q;
    logic          rise, fall;
    logic          short_n, long_n, double_n;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            btn_q        <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
            event_count  <= 8'd0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            btn_q        <= btn;
            short_pulse  <= short_n;
            long_pulse   <= long_n;
            double_pulse <= double_n;
            if (short_n || long_n || double_n)
                event_count <= event_count + 8'd1;
        end
    end

    // Edge checks come before timer checks so fall/rise win ties with the threshold.
    always_comb begin
        state_n  = state;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise)
                    state_n = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_n = WAIT2;
                end else if (timer == LONG_LAST) begin
                    state_n = HELD;
                    long_n  = 1'b1;
                end
            end
            HELD: begin
                if (fall)
                    state_n = IDLE;
            end
            WAIT2: begin
                if (rise) begin
                    state_n  = PRESS2;
                    double_n = 1'b1;
                end else if (timer == DOUBLE_LAST) begin
                    state_n = IDLE;
                    short_n = 1'b1;
                end
            end
            PRESS2: begin
                if (fall)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state)
            timer_n = '0;
        else if (state == PRESS1 || state == WAIT2)
            timer_n = timer + 1'b1;
        else
            timer_n = '0;
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - randomized self-checking bench for button_press_classifier
module tb_button_press_classifier;

    localparam int LT = 10;
    localparam int DT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       short_pulse;
    logic       long_pulse;
    logic       double_pulse;
    logic [7:0] event_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int seen_short = 0;
    int lvl[$];
    logic [2:0] exp_code[$];

    button_press_classifier #(
        .CLK_HZ   (1000),
        .LONG_MS  (10),
        .DOUBLE_MS(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    task automatic add(input int v, input int len);
        for (int k = 0; k < len; k++) lvl.push_back(v);
    endtask

    function automatic int run_len(input int from, input int v);
        int k = from;
        while (k < lvl.size() && lvl[k] == v) k++;
        return k - from;
    endfunction

    // Gesture-level model: press run length h, gap length g decide the class and pulse time.
    task automatic build_model();
        int n = lvl.size();
        int i = 0;
        int s, h, f, g, r;
        exp_code.delete();
        for (int k = 0; k < n; k++) exp_code.push_back(3'b000);
        while (i < n) begin
            if (lvl[i] == 1 && (i == 0 || lvl[i-1] == 0)) begin
                s = i;
                h = run_len(s, 1);
                if (h > LT) begin
                    if (s + LT + 1 < n) exp_code[s + LT + 1] = 3'b010;
                    i = s + h;
                end else begin
                    f = s + h;
                    g = run_len(f, 0);
                    if (f + g < n && g <= DT) begin
                        r = f + g;
                        if (r + 1 < n) exp_code[r + 1] = 3'b001;
                        i = r + run_len(r, 1);
                    end else begin
                        if (f + DT + 1 < n) exp_code[f + DT + 1] = 3'b100;
                        i = f + g;
                    end
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_seq(input string name);
        int n;
        build_model();
        n = lvl.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (exp_code[c] != 3'b000) exp_cnt = (exp_cnt + 1) % 256;
            if (short_pulse) seen_short++;
            checks++;
            if ({short_pulse, long_pulse, double_pulse} !== exp_code[c] ||
                event_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL %s cycle %0d: got s/l/d=%b count=%0d, expected s/l/d=%b count=%0d",
                         name, c, {short_pulse, long_pulse, double_pulse}, event_count,
                         exp_code[c], exp_cnt);
            end
            btn = (lvl[c] != 0);
        end
        lvl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({short_pulse, long_pulse, double_pulse, event_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b, expected 0",
                     {short_pulse, long_pulse, double_pulse, event_count});
        end
        rst_n = 1'b1;
        add(1, 3); add(0, 10);
        run_seq("pre_reset_short");
        @(posedge clk);
        #1 btn = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({short_pulse, long_pulse, double_pulse, event_count} !== 11'd0) begin
            errors++;
            $display("FAIL mid_press_reset: got %b, expected 0",
                     {short_pulse, long_pulse, double_pulse, event_count});
        end
        btn = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 20);
        run_seq("post_reset_quiet");
    endtask

    task automatic test_short();
        add(1, 3); add(0, 12);
        run_seq("short");
    endtask

    task automatic test_long();
        add(1, 20); add(0, 12);
        run_seq("long");
    endtask

    task automatic test_double();
        add(1, 2); add(0, 3); add(1, 2); add(0, 12);
        run_seq("double");
    endtask

    task automatic test_boundaries();
        add(1, LT); add(0, 12);
        run_seq("release_at_threshold");
        add(1, LT + 1); add(0, 12);
        run_seq("one_past_threshold");
        add(1, 2); add(0, DT); add(1, 2); add(0, 12);
        run_seq("rise_at_timeout");
        add(1, 2); add(0, DT + 1); add(1, 2); add(0, 12);
        run_seq("rise_after_timeout");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            add(1, $urandom_range(1, 14));
            add(0, $urandom_range(1, 9));
        end
        add(0, 16);
        run_seq("random");
    endtask

    task automatic test_wrap();
        do_reset();
        seen_short = 0;
        for (int k = 0; k < 256; k++) begin
            add(1, 1); add(0, 7);
        end
        add(0, 8);
        run_seq("wrap");
        checks++;
        if (seen_short != 256 || event_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_total: got shorts=%0d count=%0d, expected shorts=256 count=0",
                     seen_short, event_count);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundaries();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
